sss_com_tx_arb: RTL and testbench
=================================

Name: sss_com_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one 38400-baud UART transmitter (clk5 domain, 8N1) between 4 byte-producing requesters.
- Drives the transmitter's sbyte/send inputs and watches its busy output.
- In header mode, prefixes each data byte with a channel-ID byte so the far end can demultiplex.
- Sits between the local producers (status, debug, reply logic) and the UART transmitter.

Parameters:
- NREQ, 4, number of requesters; fixed at 4, grant_id width 2.
- HDR_EN, 1, 1 = send header byte before each data byte; 0 = data byte only.
- HDR_TAG, 6'b101010, upper 6 bits of header byte; header = {HDR_TAG, grant_id}.
- TMO, 8'd255, clk5 cycles to wait for uart_busy to rise after a send pulse before abandoning the byte.

Ports:
- clk5  in  1  5 MHz system clock
- reset  in  1  reset, asynchronous, active-high
- req  in  4  per-requester byte request, level; held until matching ack
- data  in  32  requester byte i on data[8*i+7:8*i]; stable while req[i]=1
- ack  out  4  one-cycle pulse; byte of requester i latched
- uart_sbyte  out  8  byte to transmitter
- uart_send  out  1  one-cycle start pulse to transmitter
- uart_busy  in  1  transmitter busy (high from 1 cycle after send until stop bit done)
- grant_id  out  2  requester currently being served
- active  out  1  high whenever state != IDLE
- tmo_err  out  1  one-cycle pulse on start timeout

Behaviour:
- All outputs registered.
- Reset values: ack=0, uart_sbyte=0, uart_send=0, grant_id=0, active=0, tmo_err=0, state=IDLE, rr_ptr=0, phase=DATA.
- Round robin: search order rr_ptr, rr_ptr+1, … mod 4. The first asserted req wins. After a completed or abandoned transfer, rr_ptr <= winner+1 (wraps 3->0).
- States: IDLE, WAIT_HI, WAIT_LO.
- IDLE: if uart_busy=0 and req!=0 at edge T, then:
  - data_reg <= winner's byte; grant_id <= winner; ack[winner] <= 1 (high in cycle T+1 only).
  - uart_send <= 1 (T+1 only).
  - uart_sbyte <= header if HDR_EN, else data byte; phase <= HDR if HDR_EN, else DATA.
  - tmo_cnt <= 0; -> WAIT_HI.
- IDLE with uart_busy=1 (including the ~10 bit times after reset while the transmitter drains): no grant, no send.
- WAIT_HI:
  - uart_busy=1 -> WAIT_LO.
  - Otherwise tmo_cnt++; when tmo_cnt==TMO: tmo_err pulse, rr_ptr update, phase <= DATA, -> IDLE (byte lost).
- WAIT_LO: wait for uart_busy=0, then:
  - phase=HDR: uart_sbyte <= data_reg, uart_send <= 1 (one cycle), phase <= DATA, tmo_cnt <= 0, -> WAIT_HI.
  - phase=DATA: rr_ptr update, -> IDLE.
- uart_send is never asserted while uart_busy=1. A send during busy would restart the frame mid-byte.
- The header and its data byte are never interleaved with another requester's bytes.
- Requester protocol: deassert req, or present the next byte, in the cycle ack is seen. req is only sampled in IDLE, so req still high after ack means a new byte.
- req dropped before ack: request withdrawn, no ack.
- uart_sbyte holds its value until the next load.
- Reset mid-transfer: everything returns to reset values immediately, with no send pulse. The transmitter's own reset handles its line.
- Minimum spacing between sends: 1 frame (~1300 clk5 cycles) per byte.

Test Plan:
- Reset released, req=4'b0001, data[7:0]=8'h55, HDR_EN=1, busy model high for 1300 cycles after reset:
  - No send until busy falls.
  - Then ack[0] pulse, uart_sbyte=8'hA8, one send pulse.
  - After busy falls, second send with uart_sbyte=8'h55, then IDLE.
- req=4'b1111 held continuously, bytes 8'h10/11/12/13, rr_ptr=0: serve order 0,1,2,3,0; exactly one ack per service; grant_id follows that order.
- HDR_EN=0, req=4'b0100, data=8'hC3: single send with 8'hC3; ack[2] in the same cycle as uart_send.
- Busy model never rises after send: after TMO=255 cycles, one tmo_err pulse, return to IDLE, rr_ptr advanced. The next request is served normally.
- Reset asserted in WAIT_LO during the header phase: all outputs 0 the same cycle, no data byte sent. After release, the pending req is re-served from header with a fresh ack.
- Assertion over all tests: uart_send=1 implies uart_busy=0 in the same cycle. ack is one-hot and at most one cycle wide.

Source files
------------

// File: rtl/sss_com_tx_arb.sv
// Round-robin arbiter/sequencer sharing one 8N1 UART transmitter between
// four byte producers, optionally prefixing each byte with a channel-ID header.
module sss_com_tx_arb #(
  parameter int unsigned NREQ    = 4,
  parameter bit          HDR_EN  = 1'b1,
  parameter logic [5:0]  HDR_TAG = 6'b101010,
  parameter logic [7:0]  TMO     = 8'd255
) (
  input  logic              clk5,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        uart_sbyte,
  output logic              uart_send,
  input  logic              uart_busy,
  output logic [1:0]        grant_id,
  output logic              active,
  output logic              tmo_err
);

  localparam int unsigned IDW = 2;
  localparam int unsigned BW  = 8;
  localparam int unsigned CW  = 8;

  localparam logic PH_DATA = 1'b0;
  localparam logic PH_HDR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             phase_q, phase_d;
  logic [BW-1:0]    data_q, data_d;
  logic [CW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [BW-1:0]    sbyte_q, sbyte_d;
  logic             send_q, send_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic             active_q, active_d;
  logic             tmo_err_q, tmo_err_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   scan_idx;
  logic [BW-1:0]    win_byte;

  // Round-robin search starting at rr_ptr; first asserted request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = rr_ptr_q + IDW'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign win_byte = data[{win_idx, 3'b000} +: BW];

  // Next-state and registered-output logic for the send sequencer.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    phase_d   = phase_q;
    data_d    = data_q;
    tmo_cnt_d = tmo_cnt_q;
    ack_d     = '0;
    sbyte_d   = sbyte_q;
    send_d    = 1'b0;
    gid_d     = gid_q;
    tmo_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Grant only when the transmitter is idle so a send never lands mid-frame.
        if (!uart_busy && win_found) begin
          data_d    = win_byte;
          gid_d     = win_idx;
          ack_d     = NREQ'(1) << win_idx;
          send_d    = 1'b1;
          sbyte_d   = HDR_EN ? {HDR_TAG, win_idx} : win_byte;
          phase_d   = HDR_EN ? PH_HDR : PH_DATA;
          tmo_cnt_d = '0;
          state_d   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (uart_busy) begin
          state_d = WAIT_LO;
        end else if (tmo_cnt_q == TMO) begin
          // Transmitter never started: drop the byte and move the pointer on.
          tmo_err_d = 1'b1;
          rr_ptr_d  = gid_q + IDW'(1);
          phase_d   = PH_DATA;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
      end
      WAIT_LO: begin
        if (!uart_busy) begin
          if (phase_q == PH_HDR) begin
            // Header done; follow immediately with the latched data byte.
            sbyte_d   = data_q;
            send_d    = 1'b1;
            phase_d   = PH_DATA;
            tmo_cnt_d = '0;
            state_d   = WAIT_HI;
          end else begin
            rr_ptr_d = gid_q + IDW'(1);
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    active_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      phase_q   <= PH_DATA;
      data_q    <= '0;
      tmo_cnt_q <= '0;
      ack_q     <= '0;
      sbyte_q   <= '0;
      send_q    <= 1'b0;
      gid_q     <= '0;
      active_q  <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      phase_q   <= phase_d;
      data_q    <= data_d;
      tmo_cnt_q <= tmo_cnt_d;
      ack_q     <= ack_d;
      sbyte_q   <= sbyte_d;
      send_q    <= send_d;
      gid_q     <= gid_d;
      active_q  <= active_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign ack        = ack_q;
  assign uart_sbyte = sbyte_q;
  assign uart_send  = send_q;
  assign grant_id   = gid_q;
  assign active     = active_q;
  assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_sss_com_tx_arb.sv
// Scoreboard bench for sss_com_tx_arb: one header-mode and one raw-mode instance,
// each with a simple transmitter busy model.
module tb_sss_com_tx_arb;

  localparam int unsigned FRAME   = 30;
  localparam int unsigned BOOT    = 1300;
  localparam int unsigned TMO_CYC = 255;

  typedef struct packed {
    logic       tmo;
    logic [7:0] sbyte;
    logic [1:0] gid;
    logic [3:0] ack;
  } exp_t;

  logic clk5 = 1'b0;
  logic reset;

  logic [3:0]  req     [2];
  logic [31:0] data    [2];
  logic [3:0]  ack     [2];
  logic [7:0]  sbyte   [2];
  logic        send    [2];
  logic        busy    [2];
  logic [1:0]  gid     [2];
  logic        active  [2];
  logic        tmo_err [2];

  int unsigned bcnt [2];
  bit          mute [2];
  int          hold [2][4];

  exp_t        sb [2][$];

  int          checks = 0;
  int          errors = 0;
  int          wd_fail = 0;
  bit          fin = 1'b0;
  longint      cyc = 0;
  longint      last_send [2];
  logic [3:0]  prev_ack [2];
  exp_t        e_exp, e_got;

  always #5 clk5 = ~clk5;

  sss_com_tx_arb #(.NREQ(4), .HDR_EN(1'b1), .HDR_TAG(6'b101010), .TMO(8'd255)) u_hdr (
    .clk5(clk5), .reset(reset), .req(req[0]), .data(data[0]), .ack(ack[0]),
    .uart_sbyte(sbyte[0]), .uart_send(send[0]), .uart_busy(busy[0]),
    .grant_id(gid[0]), .active(active[0]), .tmo_err(tmo_err[0])
  );

  sss_com_tx_arb #(.NREQ(4), .HDR_EN(1'b0), .HDR_TAG(6'b101010), .TMO(8'd255)) u_raw (
    .clk5(clk5), .reset(reset), .req(req[1]), .data(data[1]), .ack(ack[1]),
    .uart_sbyte(sbyte[1]), .uart_send(send[1]), .uart_busy(busy[1]),
    .grant_id(gid[1]), .active(active[1]), .tmo_err(tmo_err[1])
  );

  // Transmitter model: busy for BOOT cycles after reset, FRAME cycles after each send.
  always @(posedge clk5) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) bcnt[i] <= BOOT;
      else if (send[i] && !mute[i]) bcnt[i] <= FRAME;
      else if (bcnt[i] != 0) bcnt[i] <= bcnt[i] - 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) busy[i] = (bcnt[i] != 0);
  end

  // Monitor: protocol assertions plus scoreboard pops on every send or timeout.
  always @(negedge clk5) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        checks++;
        if ({ack[i], sbyte[i], send[i], gid[i], active[i], tmo_err[i]} != '0) begin
          errors++;
          $display("FAIL reset_zero[%0d]: ack=%b sbyte=%h send=%b gid=%0d active=%b tmo_err=%b, expected all zero",
                   i, ack[i], sbyte[i], send[i], gid[i], active[i], tmo_err[i]);
        end
        prev_ack[i] = '0;
      end else begin
        if (send[i]) begin
          checks++;
          if (busy[i]) begin
            errors++;
            $display("FAIL send_while_busy[%0d]: send=1 busy=%b, expected busy=0", i, busy[i]);
          end
        end
        if (ack[i] != '0) begin
          checks++;
          if (!$onehot(ack[i]) || ((ack[i] & prev_ack[i]) != '0)) begin
            errors++;
            $display("FAIL ack_shape[%0d]: ack=%b prev=%b, expected one-hot single-cycle", i, ack[i], prev_ack[i]);
          end
        end
        prev_ack[i] = ack[i];
        if (send[i] || tmo_err[i]) begin
          checks++;
          e_got = exp_t'({tmo_err[i], sbyte[i], gid[i], ack[i]});
          if (sb[i].size() == 0) begin
            errors++;
            $display("FAIL unexpected_event[%0d]: got tmo=%b sbyte=%h gid=%0d ack=%b, expected nothing",
                     i, e_got.tmo, e_got.sbyte, e_got.gid, e_got.ack);
          end else begin
            e_exp = sb[i].pop_front();
            if (e_got != e_exp || (send[i] && !active[i])) begin
              errors++;
              $display("FAIL event[%0d]: got tmo=%b sbyte=%h gid=%0d ack=%b active=%b, expected tmo=%b sbyte=%h gid=%0d ack=%b active=1",
                       i, e_got.tmo, e_got.sbyte, e_got.gid, e_got.ack, active[i],
                       e_exp.tmo, e_exp.sbyte, e_exp.gid, e_exp.ack);
            end
          end
          if (tmo_err[i]) begin
            checks++;
            if ((cyc - last_send[i]) < longint'(TMO_CYC) || (cyc - last_send[i]) > longint'(TMO_CYC + 2)) begin
              errors++;
              $display("FAIL tmo_delay[%0d]: %0d cycles after send, expected %0d..%0d",
                       i, cyc - last_send[i], TMO_CYC, TMO_CYC + 2);
            end
          end
          if (send[i]) last_send[i] = cyc;
        end
      end
    end
    if (fin) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (sb[i].size() != 0) begin
          errors++;
          $display("FAIL leftover[%0d]: %0d expected events never seen, expected 0", i, sb[i].size());
        end
      end
      checks++;
      if (wd_fail != 0) begin
        errors++;
        $display("FAIL watchdog: %0d waits expired, expected 0", wd_fail);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  function automatic logic [7:0] hdr(input logic [1:0] g);
    return {6'b101010, g};
  endfunction

  task automatic push(input int i, input logic t, input logic [7:0] b,
                      input logic [1:0] g, input logic [3:0] a);
    exp_t e;
    e.tmo = t; e.sbyte = b; e.gid = g; e.ack = a;
    sb[i].push_back(e);
  endtask

  // One cycle; requesters drop req once they have seen their last ack.
  task automatic step();
    @(negedge clk5);
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 4; r++) begin
        if (!reset && req[i][r] && ack[i][r]) begin
          if (hold[i][r] > 1) hold[i][r]--;
          else begin
            req[i][r] = 1'b0;
            hold[i][r] = 0;
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n = 0;
    while (!(!active[i] && sb[i].size() == 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) wd_fail++;
    repeat (2) step();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = '0; data[i] = '0; mute[i] = 1'b0; last_send[i] = 0; prev_ack[i] = '0;
      for (int r = 0; r < 4; r++) hold[i][r] = 0;
    end
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (4) step();
    reset = 1'b0;

    // Header mode byte 0x55 after boot busy; raw mode byte 0xC3 on requester 2.
    data[0] = 32'h0000_0055; hold[0][0] = 1;
    push(0, 1'b0, 8'hA8, 2'd0, 4'b0001);
    push(0, 1'b0, 8'h55, 2'd0, 4'b0000);
    req[0] = 4'b0001;
    data[1] = 32'h00C3_0000; hold[1][2] = 1;
    push(1, 1'b0, 8'hC3, 2'd2, 4'b0100);
    req[1] = 4'b0100;
    wait_idle(0, 3000);
    wait_idle(1, 3000);

    // Serve requester 3 so the pointer wraps to 0.
    data[0] = 32'h7700_0000; hold[0][3] = 1;
    push(0, 1'b0, hdr(2'd3), 2'd3, 4'b1000);
    push(0, 1'b0, 8'h77, 2'd3, 4'b0000);
    req[0] = 4'b1000;
    wait_idle(0, 500);

    // All four requesting: order 0,1,2,3,0.
    data[0] = 32'h1312_1110;
    hold[0][0] = 2; hold[0][1] = 1; hold[0][2] = 1; hold[0][3] = 1;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] g;
      g = 2'(k % 4);
      push(0, 1'b0, hdr(g), g, 4'b0001 << g);
      push(0, 1'b0, 8'h10 + 8'(g), g, 4'b0000);
    end
    req[0] = 4'b1111;
    wait_idle(0, 2000);

    // Transmitter never starts: header lost, timeout pulse.
    mute[0] = 1'b1;
    data[0] = 32'h0000_2100; hold[0][1] = 1;
    push(0, 1'b0, hdr(2'd1), 2'd1, 4'b0010);
    push(0, 1'b1, hdr(2'd1), 2'd1, 4'b0000);
    req[0] = 4'b0010;
    wait_idle(0, 1000);
    mute[0] = 1'b0;

    // Pointer advanced past 1: requester 2 beats 1, then 1 is served.
    data[0] = 32'h0032_3100; hold[0][1] = 1; hold[0][2] = 1;
    push(0, 1'b0, hdr(2'd2), 2'd2, 4'b0100);
    push(0, 1'b0, 8'h32, 2'd2, 4'b0000);
    push(0, 1'b0, hdr(2'd1), 2'd1, 4'b0010);
    push(0, 1'b0, 8'h31, 2'd1, 4'b0000);
    req[0] = 4'b0110;
    wait_idle(0, 1000);

    // Reset during the header frame: data byte never sent, re-served afterwards.
    data[0] = 32'h0000_0044; hold[0][0] = 2;
    push(0, 1'b0, 8'hA8, 2'd0, 4'b0001);
    req[0] = 4'b0001;
    begin
      int n = 0;
      while (!(active[0] && busy[0]) && n < 3000) begin
        step();
        n++;
      end
      if (n >= 3000) wd_fail++;
    end
    repeat (5) step();
    @(posedge clk5);
    #1 reset = 1'b1;
    repeat (3) step();
    push(0, 1'b0, 8'hA8, 2'd0, 4'b0001);
    push(0, 1'b0, 8'h44, 2'd0, 4'b0000);
    reset = 1'b0;
    wait_idle(0, 3000);

    fin = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
